// File: rtl/conversor_bcd.sv
// rtl/conversor_bcd.sv - two-score binary to six-digit BCD converter (shift-and-add-3), optional CONVERSOR_AUTO_UPDATE_EN
module conversor_bcd #(
  parameter int WIDTH     = 10,
  parameter int MAX_SCORE = 999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] score1,
  input  logic [WIDTH-1:0] score2,
  output logic             busy,
  output logic             done,
  output logic             saturado,
  output logic [3:0]       dig0_dec,
  output logic [3:0]       dig1_dec,
  output logic [3:0]       dig2_dec,
  output logic [3:0]       dig3_dec,
  output logic [3:0]       dig4_dec,
  output logic [3:0]       dig5_dec
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_SCORE);
  localparam logic [3:0]       CNT_LAST = 4'(WIDTH - 1);

  state_t           state;
  logic [11:0]      bcd1, bcd2;
  logic [WIDTH-1:0] bin1, bin2;
  logic [3:0]       cnt;
  logic             sat_pend;
  logic             trig;
  logic [11:0]      adj1, adj2;
  logic [WIDTH+11:0] sh1, sh2;

  // Correct every BCD nibble that would overflow past 9 after doubling
  function automatic logic [11:0] add3(input logic [11:0] b);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
    end
    return r;
  endfunction

`ifdef CONVERSOR_AUTO_UPDATE_EN
  logic [WIDTH-1:0] last1, last2;
  assign trig = start || (score1 != last1) || (score2 != last2);
`else
  assign trig = start;
`endif

  // One double-dabble step for both scores: adjust, then shift binary MSB into BCD
  always_comb begin
    adj1 = add3(bcd1);
    adj2 = add3(bcd2);
    sh1  = {adj1, bin1} << 1;
    sh2  = {adj2, bin2} << 1;
  end

  // Conversion FSM; digits and saturado only change together in DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      bcd1     <= '0;
      bcd2     <= '0;
      bin1     <= '0;
      bin2     <= '0;
      cnt      <= '0;
      sat_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      saturado <= 1'b0;
      dig0_dec <= '0;
      dig1_dec <= '0;
      dig2_dec <= '0;
      dig3_dec <= '0;
      dig4_dec <= '0;
      dig5_dec <= '0;
`ifdef CONVERSOR_AUTO_UPDATE_EN
      last1    <= '0;
      last2    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (trig) begin
            bin1     <= (score1 > MAX_V) ? MAX_V : score1;
            bin2     <= (score2 > MAX_V) ? MAX_V : score2;
            sat_pend <= (score1 > MAX_V) || (score2 > MAX_V);
            bcd1     <= '0;
            bcd2     <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= SHIFT;
`ifdef CONVERSOR_AUTO_UPDATE_EN
            last1    <= score1;
            last2    <= score2;
`endif
          end
        end
        SHIFT: begin
          bcd1 <= sh1[WIDTH+11:WIDTH];
          bin1 <= sh1[WIDTH-1:0];
          bcd2 <= sh2[WIDTH+11:WIDTH];
          bin2 <= sh2[WIDTH-1:0];
          cnt  <= cnt + 4'd1;
          if (cnt == CNT_LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
          dig0_dec <= bcd2[3:0];
          dig1_dec <= bcd2[7:4];
          dig2_dec <= bcd2[11:8];
          dig3_dec <= bcd1[3:0];
          dig4_dec <= bcd1[7:4];
          dig5_dec <= bcd1[11:8];
          saturado <= sat_pend;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conversor_bcd.sv
// tb/tb_conversor_bcd.sv - randomized model-checked bench for conversor_bcd
module tb_conversor_bcd;

  localparam int WIDTH = 10;
  localparam int MAXS  = 999;
  localparam int LAT   = WIDTH + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] score1 = '0;
  logic [WIDTH-1:0] score2 = '0;
  logic             busy, done, saturado;
  logic [3:0]       dig0_dec, dig1_dec, dig2_dec, dig3_dec, dig4_dec, dig5_dec;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  conversor_bcd #(.WIDTH(WIDTH), .MAX_SCORE(MAXS)) dut (
    .clk(clk), .reset(reset), .start(start), .score1(score1), .score2(score2),
    .busy(busy), .done(done), .saturado(saturado),
    .dig0_dec(dig0_dec), .dig1_dec(dig1_dec), .dig2_dec(dig2_dec),
    .dig3_dec(dig3_dec), .dig4_dec(dig4_dec), .dig5_dec(dig5_dec)
  );

  always #5 clk = ~clk;

  function automatic int bcd3(input int v);
    return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  function automatic int sat(input int v);
    return (v > MAXS) ? MAXS : v;
  endfunction

  function automatic int digs();
    return {dig5_dec, dig4_dec, dig3_dec, dig2_dec, dig1_dec, dig0_dec};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a conversion is a countdown of LAT edges, result from plain arithmetic
  int m_left = 0;
  int m_digs = 0;
  int m_sat  = 0;
  int m_done = 0;
  int p_digs = 0;
  int p_sat  = 0;
  int m_last1 = 0;
  int m_last2 = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left = 0; m_digs = 0; m_sat = 0; m_done = 0;
      p_digs = 0; p_sat = 0; m_last1 = 0; m_last2 = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_digs = p_digs;
          m_sat  = p_sat;
          m_done = 1;
        end
      end else if (start
`ifdef CONVERSOR_AUTO_UPDATE_EN
                   || int'(score1) != m_last1 || int'(score2) != m_last2
`endif
                  ) begin
        m_left  = LAT;
        p_digs  = (bcd3(sat(int'(score1))) << 12) | bcd3(sat(int'(score2)));
        p_sat   = (int'(score1) > MAXS || int'(score2) > MAXS) ? 1 : 0;
        m_last1 = int'(score1);
        m_last2 = int'(score2);
      end
    end
  end

  // Compare all outputs against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", int'(busy), (m_left > 0) ? 1 : 0);
      chk("done", int'(done), m_done);
      chk("saturado", int'(saturado), m_sat);
      chk("digits", digs(), m_digs);
    end
  end

  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Pulse start with given scores and return cycles from start edge to done (0 if none)
  task automatic run_conv(input int s1, input int s2, output int lat);
    score1 = WIDTH'(s1);
    score2 = WIDTH'(s2);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk("latency", lat, LAT);
  endtask

  int lat;
  int n_done;
  int cap;

  initial begin
    chk("model_bcd_123", bcd3(123), 'h123);
    chk("model_sat", sat(1023), 999);
    go(3);
    chk("reset_busy", int'(busy), 0);
    chk("reset_digits", digs(), 0);
    reset  = 1'b1;
    chk_on = 1'b1;
    go(2);

    run_conv(123, 7, lat);
    chk("d_123_7", digs(), 'h123007);
    chk("sat_123_7", int'(saturado), 0);

    run_conv(999, 0, lat);
    chk("d_999_0", digs(), 'h999000);
    chk("sat_999_0", int'(saturado), 0);

    run_conv(1023, 1000, lat);
    chk("d_sat", digs(), 'h999999);
    chk("sat_1023", int'(saturado), 1);
    go(3);

    // Extra start and score change mid-conversion must not disturb the result
    score1 = 10'd45;
    score2 = 10'd310;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    n_done = 0;
    cap    = -1;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (n_done == 0) cap = digs();
        n_done++;
      end
      if (i == 4) begin
        start  = 1'b1;
        score1 = 10'd88;
      end
      if (i == 5) start = 1'b0;
    end
    chk("d_45_310", cap, 'h045310);
`ifndef CONVERSOR_AUTO_UPDATE_EN
    chk("one_done", n_done, 1);
`endif
    go(25);

    // Reset in the middle of a conversion aborts it
    score1 = 10'd500;
    score2 = 10'd0;
    start  = 1'b1;
    go(1);
    start = 1'b0;
    go(5);
    reset = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_digits", digs(), 0);
    go(2);
    score1 = 10'd0;
    reset  = 1'b1;
    go(2);
    run_conv(500, 0, lat);
    chk("d_500", digs(), 'h500000);
    go(3);

`ifdef CONVERSOR_AUTO_UPDATE_EN
    // A score change alone launches a conversion
    score2 = 10'd42;
    lat = 0;
    for (int i = 0; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk("auto_latency", lat, LAT);
    chk("auto_digits", int'({dig1_dec, dig0_dec}), 'h42);
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    chk("auto_quiet", n_done, 0);
`endif

    // Randomized traffic, all checking by the per-cycle model comparison
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #2;
      start = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 5) == 0) score1 = WIDTH'($urandom_range(0, 1023));
      if ($urandom_range(0, 5) == 0) score2 = WIDTH'($urandom_range(0, 1023));
    end
    start = 1'b0;
    go(30);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
